// File: rtl/lock_cycle_controller_if.sv
// Switch/key inputs and lock water/port display outputs of the gondola lock controller.
interface lock_cycle_controller_if #(parameter int LEVEL_W = 7);
  logic               arrive_req;
  logic               depart_req;
  logic               gondola_in;
  logic               gondola_out;
  logic [LEVEL_W-1:0] lock_level;
  logic               filling;
  logic               draining;
  logic               outer_open;
  logic               inner_open;
  logic               port_moving;
  logic               busy;
  logic               dir;
  logic [3:0]         state;
  logic               cycle_done;

  modport master (
    output arrive_req, depart_req, gondola_in, gondola_out,
    input  lock_level, filling, draining, outer_open, inner_open,
           port_moving, busy, dir, state, cycle_done
  );

  modport slave (
    input  arrive_req, depart_req, gondola_in, gondola_out,
    output lock_level, filling, draining, outer_open, inner_open,
           port_moving, busy, dir, state, cycle_done
  );
endinterface

// File: rtl/lock_cycle_controller.sv
// Sequences one gondola passage: equalise to entry side, cycle its port, equalise to exit side,
// cycle that port. Arrival/departure requests are latched and served alternately when both wait.
module lock_cycle_controller #(
  parameter int LEVEL_W     = 7,
  parameter int OUTER_LEVEL = 80,
  parameter int INNER_LEVEL = 20,
  parameter int RESET_LEVEL = 20,
  parameter int STEP_TICKS  = 2,
  parameter int GATE_TICKS  = 3
) (
  input logic clk_i,
  input logic reset_i,
  lock_cycle_controller_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, EQ_A = 4'd1, OPEN_A = 4'd2, WAIT_IN = 4'd3, CLOSE_A = 4'd4,
    EQ_B = 4'd5, OPEN_B = 4'd6, WAIT_OUT = 4'd7, CLOSE_B = 4'd8
  } state_e;

  localparam logic [LEVEL_W-1:0] OUT_L   = LEVEL_W'(OUTER_LEVEL);
  localparam logic [LEVEL_W-1:0] IN_L    = LEVEL_W'(INNER_LEVEL);
  localparam logic [LEVEL_W-1:0] RST_L   = LEVEL_W'(RESET_LEVEL);
  localparam logic [7:0]         STEP_LST = 8'(STEP_TICKS - 1);
  localparam logic [7:0]         GATE_LST = 8'(GATE_TICKS - 1);

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               pend_arr_q, pend_arr_d, pend_dep_q, pend_dep_d;
  logic               dir_q, dir_d, last_dep_q, last_dep_d, done_q, done_d;
  logic               clr_arr, clr_dep, serve_dep, fill, drain, a_open, b_open;
  logic [LEVEL_W-1:0] eq_tgt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      level_q    <= RST_L;
      cnt_q      <= '0;
      pend_arr_q <= 1'b0;
      pend_dep_q <= 1'b0;
      dir_q      <= 1'b0;
      last_dep_q <= 1'b1;  // "departure served last" so arrival wins first
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      pend_arr_q <= pend_arr_d;
      pend_dep_q <= pend_dep_d;
      dir_q      <= dir_d;
      last_dep_q <= last_dep_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    last_dep_d = last_dep_q;
    done_d     = 1'b0;
    clr_arr    = 1'b0;
    clr_dep    = 1'b0;
    serve_dep  = 1'b0;
    fill       = 1'b0;
    drain      = 1'b0;
    // Entry side A is outer for arrivals, inner for departures.
    if (state_q == EQ_B) eq_tgt = dir_q ? OUT_L : IN_L;
    else                 eq_tgt = dir_q ? IN_L  : OUT_L;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend_arr_q || pend_dep_q) begin
          serve_dep  = pend_dep_q & (~pend_arr_q | ~last_dep_q);
          dir_d      = serve_dep;
          last_dep_d = serve_dep;
          clr_arr    = ~serve_dep;
          clr_dep    = serve_dep;
          state_d    = EQ_A;
        end
      end
      EQ_A, EQ_B: begin
        if (level_q == eq_tgt) begin
          cnt_d   = '0;
          state_d = (state_q == EQ_A) ? OPEN_A : OPEN_B;
        end else begin
          fill  = (level_q < eq_tgt);
          drain = ~fill;
          if (cnt_q == STEP_LST) begin
            cnt_d   = '0;
            level_d = fill ? level_q + 1'b1 : level_q - 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      OPEN_A, CLOSE_A, OPEN_B, CLOSE_B: begin
        if (cnt_q == GATE_LST) begin
          cnt_d = '0;
          case (state_q)
            OPEN_A:  state_d = WAIT_IN;
            CLOSE_A: state_d = EQ_B;
            OPEN_B:  state_d = WAIT_OUT;
            default: begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_IN:  if (bus.gondola_in)  state_d = CLOSE_A;
      WAIT_OUT: if (bus.gondola_out) state_d = CLOSE_B;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    pend_arr_d = (pend_arr_q & ~clr_arr) | bus.arrive_req;
    pend_dep_d = (pend_dep_q & ~clr_dep) | bus.depart_req;
  end

  assign a_open = (state_q == OPEN_A) || (state_q == WAIT_IN);
  assign b_open = (state_q == OPEN_B) || (state_q == WAIT_OUT);

  assign bus.lock_level  = level_q;
  assign bus.filling     = fill;
  assign bus.draining    = drain;
  assign bus.outer_open  = (a_open & ~dir_q) | (b_open & dir_q);
  assign bus.inner_open  = (a_open & dir_q) | (b_open & ~dir_q);
  assign bus.port_moving = (state_q == OPEN_A) || (state_q == CLOSE_A) ||
                           (state_q == OPEN_B) || (state_q == CLOSE_B);
  assign bus.busy        = (state_q != IDLE);
  assign bus.dir         = dir_q;
  assign bus.state       = state_q;
  assign bus.cycle_done  = done_q;
endmodule

// File: tb/tb_lock_cycle_controller.sv
// Directed bench for the lock controller: full passages both ways, arbitration, absorbed
// repeat requests, ignored gondola sensors, and reset in the middle of a drain.
module tb_lock_cycle_controller;
  localparam logic [3:0] S_IDLE = 4'd0, S_EQ_A = 4'd1, S_OPEN_A = 4'd2, S_WAIT_IN = 4'd3,
                         S_CLOSE_A = 4'd4, S_EQ_B = 4'd5, S_OPEN_B = 4'd6, S_WAIT_OUT = 4'd7,
                         S_CLOSE_B = 4'd8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_tot  = 0;

  lock_cycle_controller_if #(.LEVEL_W(7)) bus();

  lock_cycle_controller dut (.clk_i(clk), .reset_i(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      chk("both_ports_open", 32'(bus.outer_open & bus.inner_open), 0);
      chk("fill_and_drain", 32'(bus.filling & bus.draining), 0);
      if (bus.outer_open) chk("outer_open_level", 32'(bus.lock_level), 80);
      if (bus.inner_open) chk("inner_open_level", 32'(bus.lock_level), 20);
    end
  end

  // Counts cycles spent in state st (starting at a negedge), plus cycles of filling/draining.
  task automatic wait_st(input string tag, input logic [3:0] st, output int n, output int fd);
    n = 0;
    fd = 0;
    while (bus.state == st && n < 1000) begin
      n++;
      fd += int'(bus.filling) + int'(bus.draining);
      @(negedge clk);
    end
    if (n >= 1000) chk({tag, "_timeout"}, 32'(bus.state), 32'(st) + 1);
  endtask

  // Runs a passage starting at the negedge of its first EQ_A cycle, ending at the IDLE negedge.
  task automatic run_passage(input string tag, input logic d, input int eqa, input int eqb,
                             input logic poke_arr);
    int n, fd;
    logic [31:0] la, lb;
    la = d ? 32'd20 : 32'd80;
    lb = d ? 32'd80 : 32'd20;
    chk({tag, "_dir"}, 32'(bus.dir), 32'(d));
    chk({tag, "_busy"}, 32'(bus.busy), 1);
    bus.gondola_in = 1'b1;
    wait_st({tag, "_eqa"}, S_EQ_A, n, fd);
    chk({tag, "_eqa_cycles"}, n, eqa);
    chk({tag, "_eqa_steps"}, fd, eqa - 1);
    chk({tag, "_eqa_level"}, 32'(bus.lock_level), la);
    chk({tag, "_opena_outer"}, 32'(bus.outer_open), 32'(!d));
    chk({tag, "_opena_inner"}, 32'(bus.inner_open), 32'(d));
    chk({tag, "_opena_moving"}, 32'(bus.port_moving), 1);
    wait_st({tag, "_opena"}, S_OPEN_A, n, fd);
    chk({tag, "_opena_cycles"}, n, 3);
    bus.gondola_in = 1'b0;
    chk({tag, "_waitin_state"}, 32'(bus.state), 32'(S_WAIT_IN));
    chk({tag, "_waitin_moving"}, 32'(bus.port_moving), 0);
    bus.gondola_out = 1'b1;
    bus.arrive_req  = poke_arr;
    repeat (2) @(negedge clk);
    bus.gondola_out = 1'b0;
    bus.arrive_req  = 1'b0;
    @(negedge clk);
    chk({tag, "_waitin_hold"}, 32'(bus.state), 32'(S_WAIT_IN));
    bus.gondola_in = 1'b1;
    @(negedge clk);
    bus.gondola_in = 1'b0;
    chk({tag, "_closea_ports"}, 32'({bus.outer_open, bus.inner_open}), 0);
    wait_st({tag, "_closea"}, S_CLOSE_A, n, fd);
    chk({tag, "_closea_cycles"}, n, 3);
    wait_st({tag, "_eqb"}, S_EQ_B, n, fd);
    chk({tag, "_eqb_cycles"}, n, eqb);
    chk({tag, "_eqb_steps"}, fd, eqb - 1);
    chk({tag, "_eqb_level"}, 32'(bus.lock_level), lb);
    chk({tag, "_openb_outer"}, 32'(bus.outer_open), 32'(d));
    chk({tag, "_openb_inner"}, 32'(bus.inner_open), 32'(!d));
    wait_st({tag, "_openb"}, S_OPEN_B, n, fd);
    chk({tag, "_openb_cycles"}, n, 3);
    bus.gondola_in = 1'b1;
    @(negedge clk);
    bus.gondola_in = 1'b0;
    chk({tag, "_waitout_hold"}, 32'(bus.state), 32'(S_WAIT_OUT));
    bus.gondola_out = 1'b1;
    @(negedge clk);
    bus.gondola_out = 1'b0;
    wait_st({tag, "_closeb"}, S_CLOSE_B, n, fd);
    chk({tag, "_closeb_cycles"}, n, 3);
    chk({tag, "_end_state"}, 32'(bus.state), 32'(S_IDLE));
    chk({tag, "_cycle_done"}, 32'(bus.cycle_done), 1);
    chk({tag, "_end_level"}, 32'(bus.lock_level), lb);
  endtask

  initial begin
    int n, fd;
    bus.arrive_req  = 1'b0;
    bus.depart_req  = 1'b0;
    bus.gondola_in  = 1'b0;
    bus.gondola_out = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(bus.state), 32'(S_IDLE));
    chk("rst_level", 32'(bus.lock_level), 20);
    chk("rst_outputs", 32'({bus.filling, bus.draining, bus.outer_open, bus.inner_open,
                            bus.port_moving, bus.busy, bus.dir, bus.cycle_done}), 0);
    reset = 1'b0;

    // Arrival from reset level, then departure starting at level 20.
    @(negedge clk);
    bus.arrive_req = 1'b1;
    @(negedge clk);
    bus.arrive_req = 1'b0;
    chk("arr_still_idle", 32'(bus.state), 32'(S_IDLE));
    @(negedge clk);
    chk("arr_start", 32'(bus.state), 32'(S_EQ_A));
    chk("arr_filling", 32'(bus.filling), 1);
    run_passage("arr1", 1'b0, 121, 121, 1'b0);

    bus.depart_req = 1'b1;
    @(negedge clk);
    bus.depart_req = 1'b0;
    chk("done_pulse_end", 32'(bus.cycle_done), 0);
    @(negedge clk);
    chk("dep_start", 32'(bus.state), 32'(S_EQ_A));
    chk("dep_no_step", 32'({bus.filling, bus.draining}), 0);
    run_passage("dep1", 1'b1, 1, 121, 1'b0);

    // Both requests at once: arrival (departure went last), then departure, then one extra arrival.
    bus.arrive_req = 1'b1;
    bus.depart_req = 1'b1;
    @(negedge clk);
    bus.arrive_req = 1'b0;
    bus.depart_req = 1'b0;
    @(negedge clk);
    chk("sim_start", 32'(bus.state), 32'(S_EQ_A));
    run_passage("sim_arr", 1'b0, 1, 121, 1'b1);
    @(negedge clk);
    chk("sim_dep_next", 32'(bus.state), 32'(S_EQ_A));
    run_passage("sim_dep", 1'b1, 1, 121, 1'b0);
    @(negedge clk);
    chk("extra_arr_next", 32'(bus.state), 32'(S_EQ_A));
    run_passage("extra_arr", 1'b0, 1, 121, 1'b0);
    repeat (2) @(negedge clk);
    chk("only_one_extra", 32'(bus.state), 32'(S_IDLE));

    // Reset in the middle of the drain at level 50.
    bus.arrive_req = 1'b1;
    @(negedge clk);
    bus.arrive_req = 1'b0;
    @(negedge clk);
    wait_st("rst_eqa", S_EQ_A, n, fd);
    wait_st("rst_opena", S_OPEN_A, n, fd);
    bus.gondola_in = 1'b1;
    @(negedge clk);
    bus.gondola_in = 1'b0;
    wait_st("rst_closea", S_CLOSE_A, n, fd);
    n = 0;
    while (bus.lock_level != 7'd50 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("mid_eqb_state", 32'(bus.state), 32'(S_EQ_B));
    chk("mid_eqb_drain", 32'(bus.draining), 1);
    #1 reset = 1'b1;
    #1;
    chk("abort_state", 32'(bus.state), 32'(S_IDLE));
    chk("abort_level", 32'(bus.lock_level), 20);
    chk("abort_outputs", 32'({bus.filling, bus.draining, bus.outer_open, bus.inner_open,
                              bus.port_moving, bus.busy, bus.dir}), 0);
    @(negedge clk);
    reset = 1'b0;

    // After reset, simultaneous requests go to arrival first.
    bus.arrive_req = 1'b1;
    bus.depart_req = 1'b1;
    @(negedge clk);
    bus.arrive_req = 1'b0;
    bus.depart_req = 1'b0;
    @(negedge clk);
    chk("post_rst_start", 32'(bus.state), 32'(S_EQ_A));
    run_passage("post_rst_arr", 1'b0, 121, 121, 1'b0);
    @(negedge clk);
    chk("post_rst_dep_next", 32'(bus.state), 32'(S_EQ_A));
    run_passage("post_rst_dep", 1'b1, 1, 121, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
